// File: rtl/mux_scan_n.sv
// N-channel sampling multiplexer with a registered, valid/ready output stage.
// Manual mode loads mux_sel. Auto mode round-robins over the enabled channels in ch_en.
module mux_scan_n #(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       mux_sel,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      data_out,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   scan_wrap,
    output logic                   sel_err
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;

    logic              free;
    logic [N_CH-1:0]   en_rot;
    logic [SEL_W:0]    off;
    logic [SEL_W:0]    sum;
    logic              auto_hit;
    logic [SEL_W-1:0]  auto_ch;
    logic [SEL_W-1:0]  hi_ch;
    logic              man_ok;
    logic              hit;
    logic [SEL_W-1:0]  c;
    logic [DATA_W-1:0] word;
    logic [SEL_W:0]    ptr_inc;

    assign free = !out_valid_q || out_ready;

    // Rotate the enable mask so bit 0 corresponds to ptr; the lowest set bit is the next channel.
    always_comb begin
        en_rot   = N_CH'({ch_en, ch_en} >> ptr_q);
        auto_hit = 1'b0;
        off      = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en_rot[i]) begin
                auto_hit = 1'b1;
                off      = (SEL_W + 1)'(i);
            end
        end
        sum = {1'b0, ptr_q} + off;
        if (sum >= (SEL_W + 1)'(N_CH)) begin
            sum = sum - (SEL_W + 1)'(N_CH);
        end
        auto_ch = sum[SEL_W-1:0];

        hi_ch  = '0;
        man_ok = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_en[k]) begin
                hi_ch = SEL_W'(k);
            end
            if (ch_en[k] && (mux_sel == SEL_W'(k))) begin
                man_ok = 1'b1;
            end
        end
    end

    always_comb begin
        c   = mode ? auto_ch : mux_sel;
        hit = mode ? auto_hit : man_ok;

        word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (c == SEL_W'(k)) begin
                word = data_in[k*DATA_W +: DATA_W];
            end
        end

        ptr_inc = {1'b0, c} + (SEL_W + 1)'(1);
        if (ptr_inc == (SEL_W + 1)'(N_CH)) begin
            ptr_inc = '0;
        end

        out_valid_d = out_valid_q;
        data_d      = data_q;
        ch_d        = ch_q;
        wrap_d      = wrap_q;
        err_d       = 1'b0;
        ptr_d       = ptr_q;

        if (free) begin
            if (hit) begin
                out_valid_d = 1'b1;
                data_d      = word;
                ch_d        = c;
                wrap_d      = mode && (c == hi_ch);
                if (mode) begin
                    ptr_d = ptr_inc[SEL_W-1:0];
                end
            end else begin
                out_valid_d = 1'b0;
                wrap_d      = 1'b0;
                err_d       = !mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ch_q        <= '0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ch_q        <= ch_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign out_ch    = ch_q;
    assign scan_wrap = wrap_q;
    assign sel_err   = err_q;

endmodule
